divider_64b_seq: RTL and testbench
==================================

Name: divider_64b_seq

Overview:
- Iterative radix-2 restoring unsigned divider; the inverse datapath of the pipelined 64b multiplier.
- Computes iData0 / iData1 and iData0 % iData1 in WIDTH iterations, one quotient bit per cycle.
- Valid/ready handshake on both sides; shares iEn/iClr semantics with the multiplier blocks.
- Used to recover operands from products and for normalisation in unary/binary conversion paths.

Parameters:
- WIDTH, 64, operand, quotient and remainder width in bits.
- CW, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
- iClk  in  1  clock, rising edge.
- iRst  in  1  reset, synchronous, active-high.
- iEn  in  1  global enable; low freezes all state.
- iClr  in  1  synchronous abort/clear to IDLE.
- iValid  in  1  operands valid.
- oReady  out  1  block accepts operands this cycle.
- iData0  in  WIDTH  dividend (unsigned).
- iData1  in  WIDTH  divisor (unsigned).
- oValid  out  1  result valid.
- iReady  in  1  downstream accepts the result.
- oQuot  out  WIDTH  quotient.
- oRem  out  WIDTH  remainder.
- oDivZero  out  1  divisor was zero for the current result.

Behaviour:
- Only iRst, iClk and iEn define the update rules. Priority at each edge: iRst > iClr > iEn low (hold) > normal operation.
- Reset (iRst=1 at an edge):
  - state=IDLE; oValid=0; oQuot=0; oRem=0; oDivZero=0; counter=0.
  - Reset mid-operation discards the operation.
- iClr=1 (iRst=0): same effect as reset, regardless of iEn or state.
- iEn=0: no register changes. oReady forced 0. oValid and the outputs hold.
- oReady = (state==IDLE) && iEn. Combinational; no dependency on iValid.
- IDLE:
  - Acceptance occurs at an edge with iValid && oReady.
  - If iData1 != 0: latch the divisor, remainder-acc=0, quotient shift reg=iData0, counter=WIDTH. Go to CALC.
  - If iData1 == 0: oQuot=all ones, oRem=iData0, oDivZero=1. Go to DONE.
- CALC, each enabled edge:
  - trial = {rem_acc[WIDTH-1:0], q_msb} - divisor, computed at WIDTH+1 bits.
  - If trial is non-negative: rem_acc=trial and shift in quotient bit 1; otherwise shift in 0.
  - Decrement counter. On the edge where the counter goes 1->0: load oQuot/oRem, oDivZero=0, go to DONE.
  - iValid is ignored in CALC.
- DONE:
  - oValid=1; oQuot, oRem and oDivZero are stable.
  - At an enabled edge with iReady=1: go to IDLE; oValid=0 from the next cycle; output values hold.
  - There is no accept-and-complete in the same cycle. A new operand is accepted no earlier than the cycle after oValid drops.
- Latency with iEn held high, counting from the acceptance edge:
  - Normal divide: oValid is visible after WIDTH edges following the acceptance edge (WIDTH+1 edges total).
  - Divide-by-zero: oValid is visible after the acceptance edge itself (1 edge).
  - Each disabled cycle adds exactly one cycle of latency.
- Throughput: at most one operation per WIDTH+2 cycles.
- Width rules:
  - Fully unsigned; no overflow is possible. oQuot <= iData0 and oRem < iData1.
  - Invariant: oQuot*iData1 + oRem == iData0 at full 2*WIDTH precision.
- Boundaries:
  - iData0 < iData1 gives Q=0, R=iData0.
  - iData1=1 gives Q=iData0, R=0.
  - iData0=0 gives Q=0, R=0 and still takes full latency.

Test Plan:
1. Reset held 20 cycles, then release -> oValid=0, oQuot=0, oRem=0, oDivZero=0, oReady=1. Apply 100/7 -> oValid 65 edges after acceptance; Q=14, R=2, oDivZero=0.
2. Boundaries:
   - 64'hFFFF_FFFF_FFFF_FFFF / 1 -> Q=all ones, R=0.
   - 5/9 -> Q=0, R=5.
   - 64'h8000_0000_0000_0000 / 64'hFFFF_FFFF_FFFF_FFFF -> Q=0, R=64'h8000_0000_0000_0000.
3. Divide-by-zero: 123/0 -> oValid after 1 edge, Q=all ones, R=123, oDivZero=1. The next op 10/3 -> Q=3, R=1, oDivZero=0.
4. Handshake and stall:
   - Hold iReady=0 for 10 cycles in DONE -> outputs and oValid stable, oReady=0; iValid pulses during CALC/DONE are ignored.
   - iEn=0 for 5 cycles mid-CALC -> result is correct and latency is 70 edges.
5. Abort: iClr=1 for 1 cycle at iteration 30 -> IDLE next cycle, oValid=0, outputs 0. Reset mid-CALC behaves identically. A following 1000/10 -> Q=100, R=0.
6. Random: 1000 back-to-back ops with $urandom-built 64b operands (~5% zero divisors) and random iReady/iEn gaps -> every result matches the scoreboard's / and % and the invariant Q*D+R==N.

Source files
------------

// File: rtl/divider_64b_seq.sv
`timescale 1ns/1ps
// Iterative radix-2 restoring unsigned divider: one quotient bit per enabled cycle,
// valid/ready handshake on operand and result sides, divide-by-zero flagged in one edge.
module divider_64b_seq #(
  parameter  int WIDTH = 64,
  localparam int CW    = $clog2(WIDTH) + 1
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iEn,
  input  logic             iClr,
  input  logic             iValid,
  output logic             oReady,
  input  logic [WIDTH-1:0] iData0,
  input  logic [WIDTH-1:0] iData1,
  output logic             oValid,
  input  logic             iReady,
  output logic [WIDTH-1:0] oQuot,
  output logic [WIDTH-1:0] oRem,
  output logic             oDivZero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_rem_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_divzero;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH:0]   w_trial;
  logic             w_fit;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_accept;
  logic             w_last;
  logic             w_div_zero_in;

  assign oReady        = (r_state == S_IDLE) && iEn;
  assign w_accept      = oReady && iValid;
  assign w_last        = (r_cnt == CW'(1));
  assign w_div_zero_in = (iData1 == {WIDTH{1'b0}});

  assign oValid   = (r_state == S_DONE);
  assign oQuot    = r_quot;
  assign oRem     = r_rem;
  assign oDivZero = r_divzero;

  // Restoring step: the remainder stays below the divisor, so a WIDTH+1 bit trial
  // subtraction is enough and its MSB is the borrow.
  always_comb begin
    w_trial   = {r_rem_acc, r_q[WIDTH-1]} - {1'b0, r_div};
    w_fit     = ~w_trial[WIDTH];
    w_rem_nxt = w_fit ? w_trial[WIDTH-1:0] : {r_rem_acc[WIDTH-2:0], r_q[WIDTH-1]};
    w_q_nxt   = {r_q[WIDTH-2:0], w_fit};
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_div_zero_in ? S_DONE : S_CALC;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CALC: begin
        if (iEn && w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_CALC;
        end
      end
      S_DONE: begin
        if (iEn && iReady) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst || iClr) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst || iClr) begin
      r_div     <= {WIDTH{1'b0}};
      r_rem_acc <= {WIDTH{1'b0}};
      r_q       <= {WIDTH{1'b0}};
      r_quot    <= {WIDTH{1'b0}};
      r_rem     <= {WIDTH{1'b0}};
      r_divzero <= 1'b0;
      r_cnt     <= {CW{1'b0}};
    end else if (iEn) begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_div_zero_in) begin
              r_quot    <= {WIDTH{1'b1}};
              r_rem     <= iData0;
              r_divzero <= 1'b1;
            end else begin
              r_div     <= iData1;
              r_rem_acc <= {WIDTH{1'b0}};
              r_q       <= iData0;
              r_cnt     <= CW'(WIDTH);
            end
          end
        end
        S_CALC: begin
          r_rem_acc <= w_rem_nxt;
          r_q       <= w_q_nxt;
          r_cnt     <= r_cnt - CW'(1);
          if (w_last) begin
            r_quot    <= w_q_nxt;
            r_rem     <= w_rem_nxt;
            r_divzero <= 1'b0;
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_64b_seq.sv
`timescale 1ns/1ps
// Self-checking bench for divider_64b_seq: directed literal cases plus randomized
// back-to-back traffic checked every cycle against a behavioural model.
module tb_divider_64b_seq;
  localparam int W = 64;

  logic         iClk = 1'b0;
  logic         iRst, iEn, iClr, iValid, iReady;
  logic [W-1:0] iData0, iData1;
  logic         oReady, oValid, oDivZero;
  logic [W-1:0] oQuot, oRem;

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 1'b0;

  always #5 iClk = ~iClk;

  divider_64b_seq #(.WIDTH(W)) dut (
    .iClk(iClk), .iRst(iRst), .iEn(iEn), .iClr(iClr),
    .iValid(iValid), .oReady(oReady), .iData0(iData0), .iData1(iData1),
    .oValid(oValid), .iReady(iReady), .oQuot(oQuot), .oRem(oRem), .oDivZero(oDivZero)
  );

  // Behavioural model: results come from / and %, timing from a count of enabled edges left.
  logic         m_busy = 1'b0, m_valid = 1'b0, m_z = 1'b0, m_fresh = 1'b0;
  logic [W-1:0] m_q = '0, m_r = '0, m_n = '0, m_d = '0;
  logic [W-1:0] m_pq = '0, m_pr = '0, m_pn = '0, m_pd = '0;
  int           m_left = 0;
  int           m_accepts = 0;
  wire          m_idle = !m_busy && !m_valid;

  always @(posedge iClk) begin
    m_fresh <= 1'b0;
    if (iRst || iClr) begin
      m_busy <= 1'b0; m_valid <= 1'b0; m_left <= 0;
      m_q <= '0; m_r <= '0; m_z <= 1'b0;
    end else if (iEn) begin
      if (m_valid) begin
        if (iReady) m_valid <= 1'b0;
      end else if (m_busy) begin
        if (m_left == 1) begin
          m_busy <= 1'b0; m_valid <= 1'b1;
          m_q <= m_pq; m_r <= m_pr; m_z <= 1'b0; m_n <= m_pn; m_d <= m_pd;
        end
        m_left <= m_left - 1;
      end else if (iValid) begin
        m_accepts <= m_accepts + 1;
        m_fresh   <= 1'b1;
        if (iData1 == '0) begin
          m_valid <= 1'b1; m_q <= '1; m_r <= iData0; m_z <= 1'b1;
          m_n <= iData0; m_d <= '0;
        end else begin
          m_busy <= 1'b1; m_left <= W;
          m_pq <= iData0 / iData1; m_pr <= iData0 % iData1;
          m_pn <= iData0; m_pd <= iData1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle_compare();
    logic [127:0] prod;
    chk("oValid", oValid, m_valid);
    chk("oReady", oReady, m_idle && iEn);
    chk("oQuot", oQuot, m_q);
    chk("oRem", oRem, m_r);
    chk("oDivZero", oDivZero, m_z);
    if (m_valid && !m_z) begin
      prod = {64'd0, oQuot} * {64'd0, m_d} + {64'd0, oRem};
      chk("invariant", prod, {64'd0, m_n});
      chk("rem_lt_div", oRem < m_d, 1'b1);
    end
  endtask

  // One directed operation with literal expectations; optional iEn stall and iReady hold.
  task automatic do_op(input logic [W-1:0] n, input logic [W-1:0] d,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez,
                       input int elat, input int stall_at, input int hold);
    int edges;
    iReady = (hold == 0);
    iData0 = n; iData1 = d; iValid = 1'b1;
    @(posedge iClk); #1;
    edges = 1;
    iValid = 1'b0;
    while (!oValid && edges < 300) begin
      if (hold > 0) begin
        iValid = 1'($urandom_range(0, 1));
        iData0 = {$urandom, $urandom}; iData1 = {$urandom, $urandom};
      end
      if (edges == stall_at) iEn = 1'b0;
      if (edges == stall_at + 5) iEn = 1'b1;
      @(posedge iClk); #1;
      edges++;
    end
    chk("latency", edges, elat);
    chk("quot", oQuot, eq);
    chk("rem", oRem, er);
    chk("divzero", oDivZero, ez);
    for (int i = 0; i < hold; i++) begin
      iValid = 1'b1; iData0 = {$urandom, $urandom}; iData1 = 64'd3;
      @(posedge iClk); #1;
      chk("hold_valid", oValid, 1'b1);
      chk("hold_ready", oReady, 1'b0);
      chk("hold_quot", oQuot, eq);
      chk("hold_rem", oRem, er);
    end
    iValid = 1'b0; iReady = 1'b1;
    @(posedge iClk); #1;
    chk("drop_valid", oValid, 1'b0);
    chk("drop_quot", oQuot, eq);
  endtask

  task automatic abort_mid(input bit use_rst);
    iData0 = 64'd12345; iData1 = 64'd7; iValid = 1'b1;
    @(posedge iClk); #1;
    iValid = 1'b0;
    repeat (30) @(posedge iClk);
    #1;
    if (use_rst) iRst = 1'b1; else iClr = 1'b1;
    @(posedge iClk); #1;
    iRst = 1'b0; iClr = 1'b0;
    chk("abort_valid", oValid, 1'b0);
    chk("abort_quot", oQuot, 64'd0);
    chk("abort_rem", oRem, 64'd0);
    chk("abort_dz", oDivZero, 1'b0);
    chk("abort_ready", oReady, 1'b1);
  endtask

  function automatic logic [W-1:0] rnd_operand();
    logic [W-1:0] v;
    v = {$urandom, $urandom};
    case ($urandom_range(0, 3))
      0:       rnd_operand = v;
      1:       rnd_operand = v >> $urandom_range(0, 63);
      2:       rnd_operand = W'($urandom_range(0, 20));
      default: rnd_operand = v >> 32;
    endcase
  endfunction

  task automatic new_operands();
    iData0 = rnd_operand();
    if ($urandom_range(0, 99) < 5) iData1 = '0;
    else begin
      iData1 = rnd_operand();
      if (iData1 == '0) iData1 = 64'd1;
    end
  endtask

  initial begin
    int start;
    int cycles;
    iRst = 1'b1; iEn = 1'b1; iClr = 1'b0; iValid = 1'b0; iReady = 1'b1;
    iData0 = '0; iData1 = '0;
    fork
      begin
        forever begin
          @(negedge iClk);
          if (chk_on) cycle_compare();
        end
      end
      begin
        repeat (20) @(posedge iClk);
        #1;
        iRst = 1'b0;
        chk_on = 1'b1;
        chk("rst_valid", oValid, 1'b0);
        chk("rst_quot", oQuot, 64'd0);
        chk("rst_rem", oRem, 64'd0);
        chk("rst_dz", oDivZero, 1'b0);
        chk("rst_ready", oReady, 1'b1);

        do_op(64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 65, -1, 0);
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 65, -1, 0);
        do_op(64'd5, 64'd9, 64'd0, 64'd5, 1'b0, 65, -1, 0);
        do_op(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,
              64'h8000_0000_0000_0000, 1'b0, 65, -1, 0);
        do_op(64'd123, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd123, 1'b1, 1, -1, 0);
        do_op(64'd10, 64'd3, 64'd3, 64'd1, 1'b0, 65, -1, 0);
        do_op(64'd0, 64'd5, 64'd0, 64'd0, 1'b0, 65, -1, 0);
        do_op(64'd1000003, 64'd97, 64'd10309, 64'd30, 1'b0, 65, -1, 10);
        do_op(64'd1000000007, 64'd1000, 64'd1000000, 64'd7, 1'b0, 70, 10, 0);

        abort_mid(1'b0);
        abort_mid(1'b1);
        do_op(64'd1000, 64'd10, 64'd100, 64'd0, 1'b0, 65, -1, 0);

        start = m_accepts;
        cycles = 0;
        iEn = 1'b1; iReady = 1'b1;
        new_operands();
        iValid = 1'b1;
        while ((m_accepts - start) < 1000 && cycles < 85000) begin
          @(posedge iClk); #1;
          cycles++;
          if (m_fresh) new_operands();
          iEn    = ($urandom_range(0, 99) >= 2);
          iReady = ($urandom_range(0, 99) >= 20);
        end
        chk("random_ops_done", m_accepts - start, 1000);
        iValid = 1'b0; iEn = 1'b1; iReady = 1'b1;
        repeat (3) @(posedge iClk);
        #1;
      end
    join_any
    disable fork;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
